// File: rtl/ep_rx_req.sv
// TRN receive request engine: MWr32 -> write strobes, 1-DW MRd32 -> held completion request.
// Optional EP_RX_DROP_CNT_EN adds drop_cnt_o counting discarded/discontinued TLPs.
module ep_rx_req #(
    parameter int ADDR_W  = 10,
    parameter int BAR_SEL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       trn_rd,
    input  logic              trn_rsof_n,
    input  logic              trn_reof_n,
    input  logic              trn_rsrc_rdy_n,
    input  logic              trn_rsrc_dsc_n,
    input  logic [6:0]        trn_rbar_hit_n,
    output logic              trn_rdst_rdy_n,
    output logic              req_compl_o,
    input  logic              compl_done_i,
    output logic [2:0]        req_tc_o,
    output logic              req_td_o,
    output logic              req_ep_o,
    output logic [1:0]        req_attr_o,
    output logic [9:0]        req_len_o,
    output logic [15:0]       req_rid_o,
    output logic [7:0]        req_tag_o,
    output logic [7:0]        req_be_o,
    output logic [6:0]        req_addr_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [7:0]        wr_be_o
`ifdef EP_RX_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt_o
`endif
);

    typedef enum logic [2:0] {
        IDLE, RD_DW1, RD_DW2, WAIT_CPL,
        WR_DW1, WR_DW2, WR_DATA, DISCARD
    } state_t;

    localparam logic [6:0] FT_MRD32 = 7'b00_00000;
    localparam logic [6:0] FT_MWR32 = 7'b10_00000;

    state_t state, state_nxt;
    logic sof, eof, dsc, hit, accept, abort, take;
    logic [ADDR_W-1:0] cnt;

    assign sof    = ~trn_rsof_n;
    assign eof    = ~trn_reof_n;
    assign dsc    = ~trn_rsrc_dsc_n;
    assign hit    = ~trn_rbar_hit_n[BAR_SEL];
    assign accept = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
    // Discontinue never interrupts a read that is already waiting on its completion.
    assign abort  = dsc & (state != IDLE) & (state != WAIT_CPL);
    assign take   = accept & ~abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept && sof && !eof) begin
                    if (trn_rd[30:24] == FT_MRD32 && hit && trn_rd[9:0] == 10'd1)
                        state_nxt = RD_DW1;
                    else if (trn_rd[30:24] == FT_MWR32 && hit)
                        state_nxt = WR_DW1;
                    else
                        state_nxt = DISCARD;
                end
                RD_DW1:   if (accept) state_nxt = eof ? IDLE : RD_DW2;
                RD_DW2:   if (accept) state_nxt = eof ? WAIT_CPL : DISCARD;
                WAIT_CPL: if (compl_done_i) state_nxt = IDLE;
                WR_DW1:   if (accept) state_nxt = eof ? IDLE : WR_DW2;
                WR_DW2:   if (accept) state_nxt = eof ? IDLE : WR_DATA;
                WR_DATA:  if (accept && eof) state_nxt = IDLE;
                DISCARD:  if (accept && eof) state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        trn_rdst_rdy_n = (state == WAIT_CPL);
        req_compl_o    = (state == WAIT_CPL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_tc_o   <= '0;
            req_td_o   <= 1'b0;
            req_ep_o   <= 1'b0;
            req_attr_o <= '0;
            req_len_o  <= '0;
            req_rid_o  <= '0;
            req_tag_o  <= '0;
            req_be_o   <= '0;
            req_addr_o <= '0;
            rd_addr_o  <= '0;
            wr_be_o    <= '0;
            cnt        <= '0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
        end else begin
            wr_en_o <= take && (state == WR_DATA);
            if (take && state == IDLE && sof) begin
                req_tc_o   <= trn_rd[22:20];
                req_td_o   <= trn_rd[15];
                req_ep_o   <= trn_rd[14];
                req_attr_o <= trn_rd[13:12];
                req_len_o  <= trn_rd[9:0];
            end
            if (take && state == RD_DW1) begin
                req_rid_o <= trn_rd[31:16];
                req_tag_o <= trn_rd[15:8];
                req_be_o  <= trn_rd[7:0];
            end
            if (take && state == RD_DW2) begin
                req_addr_o <= {trn_rd[6:2], 2'b00};
                rd_addr_o  <= trn_rd[ADDR_W+1:2];
            end
            if (take && state == WR_DW1) wr_be_o <= trn_rd[7:0];
            if (take && state == WR_DW2) cnt <= trn_rd[ADDR_W+1:2];
            if (take && state == WR_DATA) begin
                wr_addr_o <= cnt;
                wr_data_o <= {trn_rd[7:0], trn_rd[15:8],
                              trn_rd[23:16], trn_rd[31:24]};
                cnt       <= cnt + ADDR_W'(1);
            end
        end
    end

`ifdef EP_RX_DROP_CNT_EN
    logic drop_evt;
    // A TLP already counted on entering DISCARD is not counted again if it is aborted.
    assign drop_evt = (abort && state != DISCARD)
                    || (take && state == IDLE && sof && eof)
                    || (take && state != DISCARD && state_nxt == DISCARD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_o <= '0;
        else if (drop_evt && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ep_rx_req.sv
// Directed bench for ep_rx_req: a write-expectation queue built from each
// TLP's header is checked on every write cycle, plus literal spot checks.
module tb_ep_rx_req;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   trn_rd;
    logic          trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n;
    logic [6:0]    trn_rbar_hit_n;
    logic          trn_rdst_rdy_n, req_compl_o, compl_done_i;
    logic [2:0]    req_tc_o;
    logic          req_td_o, req_ep_o;
    logic [1:0]    req_attr_o;
    logic [9:0]    req_len_o;
    logic [15:0]   req_rid_o;
    logic [7:0]    req_tag_o, req_be_o;
    logic [6:0]    req_addr_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic          wr_en_o;
    logic [31:0]   wr_data_o;
    logic [7:0]    wr_be_o;
`ifdef EP_RX_DROP_CNT_EN
    logic [15:0]   drop_cnt_o;
`endif

    ep_rx_req #(.ADDR_W(AW), .BAR_SEL(0)) dut (
        .clk(clk), .rst(rst), .trn_rd(trn_rd),
        .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
        .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rsrc_dsc_n(trn_rsrc_dsc_n),
        .trn_rbar_hit_n(trn_rbar_hit_n), .trn_rdst_rdy_n(trn_rdst_rdy_n),
        .req_compl_o(req_compl_o), .compl_done_i(compl_done_i),
        .req_tc_o(req_tc_o), .req_td_o(req_td_o), .req_ep_o(req_ep_o),
        .req_attr_o(req_attr_o), .req_len_o(req_len_o),
        .req_rid_o(req_rid_o), .req_tag_o(req_tag_o), .req_be_o(req_be_o),
        .req_addr_o(req_addr_o), .rd_addr_o(rd_addr_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o), .wr_be_o(wr_be_o)
`ifdef EP_RX_DROP_CNT_EN
        , .drop_cnt_o(drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    int            total = 0;
    int            bad = 0;
    int            wr_seen = 0;
    int            compl_cyc = 0;
    logic [AW-1:0] last_a = '0;
    logic [31:0]   last_d = '0;
    wr_t           exp_q[$];
    logic [31:0]   pkt[$];
    logic [31:0]   wdata[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en_o) begin
                wr_seen++;
                last_a = wr_addr_o;
                last_d = wr_data_o;
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 64'(wr_addr_o), 64'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr_o), 64'(e.a));
                    chk("wr_data", 64'(wr_data_o), 64'(e.d));
                end
            end
            if (req_compl_o) compl_cyc++;
        end
    end

    task automatic beat(input logic [31:0] d, input bit s, input bit e, input int idle);
        int g;
        if (idle > 0) begin
            trn_rsrc_rdy_n = 1'b1;
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
        end
        trn_rd         = d;
        trn_rsof_n     = ~s;
        trn_reof_n     = ~e;
        trn_rsrc_rdy_n = 1'b0;
        g = 0;
        while (trn_rdst_rdy_n !== 1'b0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) chk("rdy_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic stop_src();
        trn_rsrc_rdy_n = 1'b1;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input bit hit);
        trn_rbar_hit_n = hit ? 7'h7E : 7'h7F;
        for (int i = 0; i < pkt.size(); i++)
            beat(pkt[i], i == 0, i == pkt.size() - 1, 0);
        stop_src();
    endtask

    // Claimed writes land at consecutive DWs from the header address, mod 2^AW.
    task automatic mwr(input logic [31:0] baddr, input int n, input bit hit,
                       input logic [7:0] be, input int stall_idx,
                       input int stall_len, input int dsc_after);
        trn_rbar_hit_n = hit ? 7'h7E : 7'h7F;
        beat(32'h4000_0000 | 32'(n), 1'b1, 1'b0, 0);
        beat({24'h0, be}, 1'b0, 1'b0, 0);
        beat(baddr, 1'b0, 1'b0, 0);
        for (int i = 0; i < n; i++) begin
            if (i == dsc_after) break;
            beat(wdata[i], 1'b0, i == n - 1, (i == stall_idx) ? stall_len : 0);
            if (hit) exp_q.push_back('{a: AW'((baddr >> 2) + 32'(i)), d: swap(wdata[i])});
        end
        if (dsc_after >= 0) begin
            trn_rsrc_rdy_n = 1'b1;
            trn_rsrc_dsc_n = 1'b0;
            @(posedge clk);
            #1;
            trn_rsrc_dsc_n = 1'b1;
        end
        stop_src();
    endtask

    task automatic pulse_done();
        compl_done_i = 1'b1;
        @(posedge clk);
        #1;
        compl_done_i = 1'b0;
    endtask

    initial begin
        int w0, c0;
        trn_rd = '0;
        trn_rsof_n = 1'b1;
        trn_reof_n = 1'b1;
        trn_rsrc_rdy_n = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
        trn_rbar_hit_n = 7'h7F;
        compl_done_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdst_rdy_n", 64'(trn_rdst_rdy_n), 64'd0);
        chk("rst_req_compl", 64'(req_compl_o), 64'd0);
        chk("rst_wr_en", 64'(wr_en_o), 64'd0);
        chk("rst_req_len", 64'(req_len_o), 64'd0);
        chk("rst_wr_be", 64'(wr_be_o), 64'd0);
        rst = 1'b0;
        settle();

        // MWr32 len 3 at 0x10
        wdata[0] = 32'h1122_3344;
        wdata[1] = 32'h5566_7788;
        wdata[2] = 32'h99AA_BBCC;
        w0 = wr_seen;
        mwr(32'h10, 3, 1'b1, 8'hFF, -1, 0, -1);
        settle();
        chk("t1_wr_count", 64'(wr_seen - w0), 64'd3);
        chk("t1_last_addr", 64'(last_a), 64'd6);
        chk("t1_last_data", 64'(last_d), 64'hCCBB_AA99);
        chk("t1_wr_be", 64'(wr_be_o), 64'hFF);

        // MRd32 len 1 at 0x24, tc 2, attr 1
        pkt = '{32'h0020_1001, 32'h0100_050F, 32'h0000_0024};
        send_pkt(1'b1);
        chk("t2_req_compl", 64'(req_compl_o), 64'd1);
        chk("t2_rdst_rdy_n", 64'(trn_rdst_rdy_n), 64'd1);
        chk("t2_req_addr", 64'(req_addr_o), 64'h24);
        chk("t2_rd_addr", 64'(rd_addr_o), 64'd9);
        chk("t2_rid", 64'(req_rid_o), 64'h0100);
        chk("t2_tag", 64'(req_tag_o), 64'h05);
        chk("t2_be", 64'(req_be_o), 64'h0F);
        chk("t2_len", 64'(req_len_o), 64'd1);
        chk("t2_tc", 64'(req_tc_o), 64'd2);
        chk("t2_attr", 64'(req_attr_o), 64'd1);
        settle();
        chk("t2_hold_compl", 64'(req_compl_o), 64'd1);
        chk("t2_hold_rd_addr", 64'(rd_addr_o), 64'd9);
        pulse_done();
        chk("t2_done_compl", 64'(req_compl_o), 64'd0);
        chk("t2_done_rdy", 64'(trn_rdst_rdy_n), 64'd0);

        // Wrap at the top word address
        wdata[0] = 32'hDEAD_BEEF;
        wdata[1] = 32'h0102_0304;
        mwr(32'hFFC, 2, 1'b1, 8'hFF, -1, 0, -1);
        settle();
        chk("t3_wrap_addr", 64'(last_a), 64'd0);
        chk("t3_wrap_data", 64'(last_d), 64'h0403_0201);

        // Five-cycle source stall before the second data beat
        wdata[0] = 32'hA0A1_A2A3;
        wdata[1] = 32'hB0B1_B2B3;
        wdata[2] = 32'hC0C1_C2C3;
        w0 = wr_seen;
        mwr(32'h40, 3, 1'b1, 8'hFF, 1, 5, -1);
        settle();
        chk("t4_wr_count", 64'(wr_seen - w0), 64'd3);
        chk("t4_last_addr", 64'(last_a), 64'h12);

        // Dropped TLPs: MRd len 2, CplD, MWr with BAR miss
        w0 = wr_seen;
        c0 = compl_cyc;
        pkt = '{32'h0000_0002, 32'h0100_0A0F, 32'h0000_0030};
        send_pkt(1'b1);
        pkt = '{32'h4A00_0001, 32'h0000_0004, 32'h0100_0500, 32'h1234_5678};
        send_pkt(1'b1);
        wdata[0] = 32'h5555_AAAA;
        wdata[1] = 32'h6666_BBBB;
        mwr(32'h50, 2, 1'b0, 8'hFF, -1, 0, -1);
        settle();
        chk("t5_no_wr", 64'(wr_seen - w0), 64'd0);
        chk("t5_no_compl", 64'(compl_cyc - c0), 64'd0);
`ifdef EP_RX_DROP_CNT_EN
        chk("t5_drop_cnt", 64'(drop_cnt_o), 64'd3);
`endif

        // Discontinue after the second data beat of a len 4 MWr
        wdata[0] = 32'h0000_0001;
        wdata[1] = 32'h0000_0002;
        wdata[2] = 32'h0000_0003;
        wdata[3] = 32'h0000_0004;
        w0 = wr_seen;
        mwr(32'h80, 4, 1'b1, 8'h3C, -1, 0, 2);
        settle();
        chk("t6_wr_count", 64'(wr_seen - w0), 64'd2);
        chk("t6_last_addr", 64'(last_a), 64'h21);
        chk("t6_wr_be", 64'(wr_be_o), 64'h3C);
        pkt = '{32'h0000_0001, 32'h0200_0703, 32'h0000_003C};
        send_pkt(1'b1);
        chk("t6_req_compl", 64'(req_compl_o), 64'd1);
        chk("t6_rid", 64'(req_rid_o), 64'h0200);
        chk("t6_tag", 64'(req_tag_o), 64'h07);
        chk("t6_req_addr", 64'(req_addr_o), 64'h3C);
        chk("t6_rd_addr", 64'(rd_addr_o), 64'd15);
        pulse_done();
        chk("t6_done_compl", 64'(req_compl_o), 64'd0);

        settle();
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ep_rx_req.md
Name: ep_rx_req

Overview:
- Receive-side request engine for the 32-bit TRN PCIe endpoint interface.
- Parses incoming TLPs and turns 32-bit-address memory writes into write strobes for the local register/buffer memory.
- Turns 1-DW memory reads into a held completion request (req_* fields plus a level strobe) for the TX DMA/completion engine.
- Applies back-pressure until that engine reports the completion done. All other TLPs are drained and dropped.

Parameters:
- ADDR_W, 10, width of the local word (DW) address driven on rd_addr_o/wr_addr_o.
- BAR_SEL, 0, index of the trn_rbar_hit_n bit that must be low at SOF for a TLP to be claimed.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- trn_rd  in  32  TLP data beat.
- trn_rsof_n  in  1  start of frame, active low.
- trn_reof_n  in  1  end of frame, active low.
- trn_rsrc_rdy_n  in  1  source ready, active low.
- trn_rsrc_dsc_n  in  1  source discontinue, active low.
- trn_rbar_hit_n  in  7  BAR hit vector, valid with SOF.
- trn_rdst_rdy_n  out  1  destination ready, active low.
- req_compl_o  out  1  level; completion requested.
- compl_done_i  in  1  one-cycle pulse from the TX engine.
- req_tc_o  out  3  traffic class.
- req_td_o  out  1  TLP digest bit.
- req_ep_o  out  1  poisoned bit.
- req_attr_o  out  2  attributes.
- req_len_o  out  10  length in DW.
- req_rid_o  out  16  requester ID.
- req_tag_o  out  8  tag.
- req_be_o  out  8  {last_be, first_be}.
- req_addr_o  out  7  address bits [6:0], with [1:0] forced to 00.
- rd_addr_o  out  ADDR_W  read word address (address[ADDR_W+1:2]).
- wr_en_o  out  1  write strobe, one per data beat.
- wr_addr_o  out  ADDR_W  write word address.
- wr_data_o  out  32  write data, byte-swapped.
- wr_be_o  out  8  {last_be, first_be} of the current write TLP.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - trn_rdst_rdy_n=0; all other outputs 0.
- A beat is accepted only on a cycle where trn_rsrc_rdy_n=0 and trn_rdst_rdy_n=0. No state advances without acceptance.
- DW0 decode, on an accepted SOF beat in IDLE:
  - fmt/type = trn_rd[30:24].
  - 7'b00_00000 (MRd32) with bar hit and length==1 goes to RD_DW1.
  - 7'b10_00000 (MWr32) with bar hit goes to WR_DW1.
  - Any other fmt/type, length, or bar miss goes to DISCARD.
  - Latch tc/td/ep/attr/len into req_*_o.
- RD_DW1: latch rid=[31:16], tag=[15:8], be=[7:0], then go to RD_DW2.
- RD_DW2:
  - Latch req_addr_o and rd_addr_o.
  - If eof: same edge set trn_rdst_rdy_n=1 and req_compl_o=1, go to WAIT_CPL.
  - If no eof: go to DISCARD, with no completion.
- WAIT_CPL:
  - Hold all req_* and rd_addr_o stable.
  - On compl_done_i=1: next cycle req_compl_o=0, trn_rdst_rdy_n=0, state IDLE.
  - compl_done_i outside WAIT_CPL is ignored.
- WR_DW1: latch be into wr_be_o, go to WR_DW2.
- WR_DW2: load the write address counter from trn_rd[ADDR_W+1:2], go to WR_DATA.
- WR_DATA, per accepted beat:
  - Next cycle wr_en_o=1, wr_data_o={d[7:0],d[15:8],d[23:16],d[31:24]}, wr_addr_o=counter.
  - Counter then increments and wraps modulo 2^ADDR_W.
  - eof returns to IDLE.
  - Write latency is 1 cycle from acceptance.
  - Every data beat up to eof is written; the length field is not used to truncate.
- DISCARD: accept and drop beats until eof, then IDLE.
- Discontinue: trn_rsrc_dsc_n=0 in any state except WAIT_CPL aborts to IDLE.
  - No further wr_en_o.
  - No req_compl_o.
  - Writes already issued stand.
- SOF with eof on the same beat (a malformed single-beat TLP) is discarded; state stays IDLE.
- Reset during WAIT_CPL drops req_compl_o immediately.

Optional Feature:
- Macro EP_RX_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt_o[15:0], reset 0.
  - Increments, saturating at 16'hFFFF, once per TLP entering DISCARD or aborted by discontinue.
- When undefined: the port and the counter are absent.

Test Plan:
- MWr32, len=3, addr 0x0000_0010, data 0x11223344/0x55667788/0x99AABBCC → three wr_en_o pulses at addresses 4,5,6 with data 0x44332211/0x88776655/0xCCBBAA99, wr_be_o=0xFF.
- MRd32, len=1, rid 0x0100, tag 0x05, be 0x0F, addr 0x24 → req_compl_o=1 with req_addr_o=0x24, rd_addr_o=9, trn_rdst_rdy_n=1; after compl_done_i pulse, both return to 0 the next cycle.
- MWr at word address 2^ADDR_W-1, len=2 → second write lands at address 0 (wrap).
- Source holds trn_rsrc_rdy_n=1 mid-MWr for 5 cycles → no wr_en_o during the stall, data order preserved.
- MRd len=2, a CplD TLP, and a MWr with bar miss → no wr_en_o, no req_compl_o; with EP_RX_DROP_CNT_EN defined, drop_cnt_o=3.
- trn_rsrc_dsc_n=0 after the 2nd data beat of a len=4 MWr → exactly 2 writes, then IDLE; a following MRd completes normally.
